// File: rtl/mips16_ctrl_pkg.sv
// Shared control definitions for the 16-bit MIPS decode stage.
// Holds default widths, the {alu_op,func} encoding of JR, the JAL opcode
// and the state type of the jump-register redirect FSM.
package mips16_ctrl_pkg;

  localparam int MIPS_ADDR_W  = 16;
  localparam int MIPS_ALUOP_W = 2;
  localparam int MIPS_FUNC_W  = 4;

  // {alu_op,func} value that decodes to JR
  localparam logic [MIPS_ALUOP_W+MIPS_FUNC_W-1:0] MIPS_JR_CODE = 6'b001000;
  // Primary opcode of JAL (decoded upstream into is_jal)
  localparam logic [3:0] MIPS_JAL_OPCODE = 4'b0011;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack used as an advisory JR target predictor.
// Circular buffer: a push when full overwrites the oldest entry and the
// occupancy stays at DEPTH. A pop from an empty stack changes nothing.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   push, pop       push din / pop the top entry (push has priority if both)
//   din             value to push
//   top             entry[ptr-1], combinational view of the current top
//   empty, full     registered occupancy flags, reflect count after update
module ras_stack #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  ptr, ptr_nxt, ptr_m1;
  logic [PTR_W:0]    count, count_nxt;

  // DEPTH is a power of two, so the pointer wraps naturally
  assign ptr_m1 = ptr - 1'b1;
  assign top    = mem[ptr_m1];

  always_comb begin
    ptr_nxt   = ptr;
    count_nxt = count;
    if (push) begin
      ptr_nxt = ptr + 1'b1;
      if (count != DEPTH_C) count_nxt = count + 1'b1;
    end else if (pop && (count != '0)) begin
      ptr_nxt   = ptr_m1;
      count_nxt = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      ptr   <= ptr_nxt;
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == DEPTH_C);
    end
  end

  // Storage needs no reset: entries are only read while count > 0
  always_ff @(posedge clk) begin
    if (push) mem[ptr] <= din;
  end

endmodule

// File: rtl/jr_redirect_unit.sv
// Jump-register control for the decode stage: decodes JR, registers the
// redirect target, holds a multi-cycle front-end flush, and keeps a RAS
// whose prediction is scored against the real target (hit/miss counters).
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   valid_i, stall_i           decode instruction handshake (see below)
//   alu_op, func               decode fields; {alu_op,func}==JR_CODE is JR
//   is_jal, ret_addr           JAL indication and its link value (push)
//   jr_target                  register value of rs, the actual JR target
//   jr_control, redirect_valid one-cycle pulses, one cycle after JR accept
//   redirect_pc                JR target, holds its last value otherwise
//   flush                      squash fetch/decode, FLUSH_CYCLES cycles
//   pred_hit                   RAS top matched jr_target (with redirect_valid)
//   ras_empty, ras_full        RAS occupancy flags
//   hit_cnt, miss_cnt          saturating prediction counters
//   state_dbg                  current FSM state
//
// Handshake: an instruction transfers (accept) on a cycle where valid_i=1,
// stall_i=0 and the FSM is IDLE. stall_i is the inverse of ready; valid_i is
// not required to hold while stalled, and anything presented during FLUSH is
// dropped without side effects.
module jr_redirect_unit
  import mips16_ctrl_pkg::*;
#(
  parameter int ADDR_W       = MIPS_ADDR_W,
  parameter int ALUOP_W      = MIPS_ALUOP_W,
  parameter int FUNC_W       = MIPS_FUNC_W,
  parameter logic [ALUOP_W+FUNC_W-1:0] JR_CODE = MIPS_JR_CODE,
  parameter int RAS_DEPTH    = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_i,
  input  logic               stall_i,
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic [FUNC_W-1:0]  func,
  input  logic               is_jal,
  input  logic [ADDR_W-1:0]  ret_addr,
  input  logic [ADDR_W-1:0]  jr_target,
  output logic               jr_control,
  output logic               redirect_valid,
  output logic [ADDR_W-1:0]  redirect_pc,
  output logic               flush,
  output logic               pred_hit,
  output logic               ras_empty,
  output logic               ras_full,
  output logic [CNT_W-1:0]   hit_cnt,
  output logic [CNT_W-1:0]   miss_cnt,
  output state_t             state_dbg
);

  localparam int CTR_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(FLUSH_CYCLES - 1);

  state_t            state, state_nxt;
  logic [CTR_W-1:0]  flush_ctr, flush_ctr_nxt;
  logic              accept, is_jr, jr_accept, jal_push, hit;
  logic [ADDR_W-1:0] ras_top;

  assign accept    = valid_i & ~stall_i & (state == IDLE);
  assign is_jr     = ({alu_op, func} == JR_CODE);
  assign jr_accept = accept & is_jr;
  // JR wins over a simultaneous JAL flag
  assign jal_push  = accept & is_jal & ~is_jr;
  // ras_empty is registered and therefore describes the pre-pop occupancy
  assign hit       = ~ras_empty & (ras_top == jr_target);

  assign flush     = (state == FLUSH);
  assign state_dbg = state;

  ras_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .reset (reset),
    .push  (jal_push),
    .pop   (jr_accept),
    .din   (ret_addr),
    .top   (ras_top),
    .empty (ras_empty),
    .full  (ras_full)
  );

  always_comb begin
    state_nxt     = state;
    flush_ctr_nxt = flush_ctr;
    case (state)
      IDLE: begin
        if (jr_accept) begin
          state_nxt     = FLUSH;
          flush_ctr_nxt = '0;
        end
      end
      FLUSH: begin
        if (flush_ctr == CTR_LAST) state_nxt = IDLE;
        else                       flush_ctr_nxt = flush_ctr + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      flush_ctr <= '0;
    end else begin
      state     <= state_nxt;
      flush_ctr <= flush_ctr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      jr_control     <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      pred_hit       <= 1'b0;
      hit_cnt        <= '0;
      miss_cnt       <= '0;
    end else begin
      jr_control     <= jr_accept;
      redirect_valid <= jr_accept;
      pred_hit       <= jr_accept & hit;
      if (jr_accept) begin
        redirect_pc <= jr_target;
        if (hit) begin
          if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
        end else begin
          if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
        end
      end
    end
  end

endmodule
